// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter and its clients: display scan-out,
// CPU write port and the shared VRAM wrapper.
interface vram_arbiter_if;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_ready;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        cpu_wr;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_full;
  logic        cpu_overflow;
  logic        vram_rden;
  logic [13:0] vram_raddr;
  logic [15:0] vram_rdata;
  logic        vram_wren;
  logic [13:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic        vram_wrack;

  // slave is the arbiter; master is everything around it
  modport slave (
    input  disp_req, disp_addr, cpu_wr, cpu_addr, cpu_wdata, vram_rdata, vram_wrack,
    output disp_ready, disp_data, disp_valid, cpu_full, cpu_overflow,
           vram_rden, vram_raddr, vram_wren, vram_waddr, vram_wdata
  );
  modport master (
    output disp_req, disp_addr, cpu_wr, cpu_addr, cpu_wdata, vram_rdata, vram_wrack,
    input  disp_ready, disp_data, disp_valid, cpu_full, cpu_overflow,
           vram_rden, vram_raddr, vram_wren, vram_waddr, vram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shared single-port VRAM arbiter: display reads have priority over posted CPU
// writes, which drain from a small FIFO under a starvation limit and full override.
module vram_arbiter #(
  parameter int DEPTH      = 4,
  parameter int RD_LAT     = 4,
  parameter int STARVE_MAX = 2
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAT_LAST   = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] LAT_DONE   = CW'(RD_LAT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [13:0]   fifo_addr [DEPTH];
  logic [15:0]   fifo_data [DEPTH];
  logic          pending;
  logic [13:0]   pend_addr;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] starve;

  logic          disp_valid_q, overflow_q, rden_q, wren_q;
  logic [15:0]   disp_data_q, wdata_q;
  logic [13:0]   raddr_q, waddr_q;

  logic          fifo_full, fifo_empty, push, grant_wr, grant_rd;

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    push       = bus.cpu_wr && !fifo_full;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    if (state == IDLE) begin
      grant_wr = !fifo_empty && (fifo_full || starve == STARVE_TOP || !pending);
      grant_rd = !grant_wr && pending;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_addr;
      fifo_data[wr_ptr] <= bus.cpu_wdata;
    end
  end

  // NOTE: non-blocking throughout, so every decision below sees this cycle's registered state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pending      <= 1'b0;
      pend_addr    <= '0;
      lat_cnt      <= '0;
      starve       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      rden_q       <= 1'b0;
      raddr_q      <= '0;
      wren_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      // request strobes are single-cycle; only an IDLE grant raises them
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      disp_valid_q <= 1'b0;

      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (grant_wr) rd_ptr <= rd_ptr + 1'b1;
      if (push && !grant_wr)      count <= count + 1'b1;
      else if (!push && grant_wr) count <= count - 1'b1;

      if (bus.cpu_wr && fifo_full) overflow_q <= 1'b1;

      if (bus.disp_req && !pending) begin
        pending   <= 1'b1;
        pend_addr <= bus.disp_addr;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            wren_q  <= 1'b1;
            waddr_q <= fifo_addr[rd_ptr];
            wdata_q <= fifo_data[rd_ptr];
            starve  <= '0;
            state   <= WR_WAIT;
          end else if (grant_rd) begin
            rden_q  <= 1'b1;
            raddr_q <= pend_addr;
            lat_cnt <= '0;
            if (fifo_empty)                starve <= '0;
            else if (starve != STARVE_TOP) starve <= starve + 1'b1;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAT_LAST) begin
            disp_data_q  <= bus.vram_rdata;
            disp_valid_q <= 1'b1;
            pending      <= 1'b0;
          end
          // one extra cycle here keeps a freshly accepted read visible to IDLE
          if (lat_cnt == LAT_DONE) state <= IDLE;
        end
        WR_WAIT: if (bus.vram_wrack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_ready   = !pending;
  assign bus.disp_data    = disp_data_q;
  assign bus.disp_valid   = disp_valid_q;
  assign bus.cpu_full     = fifo_full;
  assign bus.cpu_overflow = overflow_q;
  assign bus.vram_rden    = rden_q;
  assign bus.vram_raddr   = raddr_q;
  assign bus.vram_wren    = wren_q;
  assign bus.vram_waddr   = waddr_q;
  assign bus.vram_wdata   = wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table of single reads/writes, then
// hand-written starvation, overflow/full-override and reset-mid-write sequences.
module tb_vram_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if bus();

  vram_arbiter #(.DEPTH(4), .RD_LAT(4), .STARVE_MAX(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // VRAM model: read data valid only in cycle R+3, write ack in cycle W+2
  logic [15:0] mem [0:16383];
  logic [2:0]  rd_sr = '0;
  logic [1:0]  ack_sr = '0;
  logic [13:0] rd_addr_q = '0;
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic        prev_rden = 1'b0, prev_wren = 1'b0;
  int          cyc = 0;
  int          viol = 0;
  logic [7:0]  grants [$];
  int          grant_cyc [$];
  logic [13:0] wlog_addr [$];
  logic [15:0] wlog_data [$];

  assign bus.vram_rdata = rd_sr[2] ? mem[rd_addr_q] : 16'h0BAD;
  assign bus.vram_wrack = ack_sr[1];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_sr  <= {rd_sr[1:0], bus.vram_rden};
    ack_sr <= {ack_sr[0], bus.vram_wren};
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.vram_rden) begin
      rd_addr_q <= bus.vram_raddr;
      grants.push_back("R");
      grant_cyc.push_back(cyc);
    end
    if (bus.vram_wren) begin
      mem[bus.vram_waddr] <= bus.vram_wdata;
      wlog_addr.push_back(bus.vram_waddr);
      wlog_data.push_back(bus.vram_wdata);
      grants.push_back("W");
      grant_cyc.push_back(cyc);
    end
    if ((bus.vram_rden && bus.vram_wren) || (bus.vram_rden && prev_rden) ||
        (bus.vram_wren && prev_wren))
      viol <= viol + 1;
    prev_rden <= bus.vram_rden;
    prev_wren <= bus.vram_wren;
  end

  task automatic preload(input logic [13:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".disp_ready"},   bus.disp_ready,   1);
    check({tag, ".disp_valid"},   bus.disp_valid,   0);
    check({tag, ".disp_data"},    bus.disp_data,    0);
    check({tag, ".cpu_full"},     bus.cpu_full,     0);
    check({tag, ".cpu_overflow"}, bus.cpu_overflow, 0);
    check({tag, ".vram_rden"},    bus.vram_rden,    0);
    check({tag, ".vram_raddr"},   bus.vram_raddr,   0);
    check({tag, ".vram_wren"},    bus.vram_wren,    0);
    check({tag, ".vram_waddr"},   bus.vram_waddr,   0);
    check({tag, ".vram_wdata"},   bus.vram_wdata,   0);
  endtask

  // Read from idle with empty FIFO: rden at A+2, disp_valid at A+6
  task automatic do_read(input logic [13:0] a, input logic [15:0] d, input string tag);
    int noisy = 0;
    check({tag, ".ready_A"}, bus.disp_ready, 1);
    bus.disp_req = 1'b1; bus.disp_addr = a;
    tick();
    bus.disp_req = 1'b0; bus.disp_addr = ~a;
    check({tag, ".ready_A1"}, bus.disp_ready, 0);
    check({tag, ".rden_A1"},  bus.vram_rden,  0);
    tick();
    check({tag, ".rden_A2"}, bus.vram_rden,  1);
    check({tag, ".raddr"},   bus.vram_raddr, a);
    for (int i = 3; i <= 5; i++) begin
      tick();
      if (bus.disp_ready || bus.disp_valid || bus.vram_rden) noisy++;
    end
    check({tag, ".quiet_A3_A5"}, noisy, 0);
    tick();
    check({tag, ".valid_A6"}, bus.disp_valid, 1);
    check({tag, ".data_A6"},  bus.disp_data,  d);
    check({tag, ".ready_A6"}, bus.disp_ready, 1);
    tick();
    check({tag, ".valid_A7"}, bus.disp_valid, 0);
    check({tag, ".data_held"}, bus.disp_data, d);
  endtask

  // Write from idle with empty FIFO: wren at C+2, ack at C+4, idle again at C+5
  task automatic do_write(input logic [13:0] a, input logic [15:0] d, input string tag);
    int n0 = wlog_addr.size();
    bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    tick();
    bus.cpu_wr = 1'b0; bus.cpu_addr = ~a; bus.cpu_wdata = ~d;
    check({tag, ".full_C1"}, bus.cpu_full, 0);
    check({tag, ".wren_C1"}, bus.vram_wren, 0);
    tick();
    check({tag, ".wren_C2"}, bus.vram_wren,  1);
    check({tag, ".waddr"},   bus.vram_waddr, a);
    check({tag, ".wdata"},   bus.vram_wdata, d);
    tick();
    check({tag, ".wren_C3"},    bus.vram_wren,  0);
    check({tag, ".waddr_held"}, bus.vram_waddr, a);
    check({tag, ".wdata_held"}, bus.vram_wdata, d);
    tick(3);
    check({tag, ".n_writes"}, wlog_addr.size(), n0 + 1);
    if (wlog_addr.size() == n0 + 1) begin
      check({tag, ".model_addr"}, wlog_addr[n0], a);
      check({tag, ".model_data"}, wlog_data[n0], d);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [13:0] addr;
    logic [15:0] data;
    bit          preload;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int gs, n0, budget;
    string exp_s;

    vecs = '{
      '{1'b0, 14'h0123, 16'hBEEF, 1'b1},
      '{1'b1, 14'h0040, 16'h1234, 1'b0},
      '{1'b0, 14'h0040, 16'h1234, 1'b0},
      '{1'b1, 14'h3FFF, 16'hFFFF, 1'b0},
      '{1'b0, 14'h3FFF, 16'hFFFF, 1'b0},
      '{1'b0, 14'h0000, 16'hA5A5, 1'b1}
    };

    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    tick(3);
    check_reset_outputs("por");
    reset = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].preload) preload(vecs[i].addr, vecs[i].data);
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      else               do_read (vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Starvation: three queued writes against a continuously re-asserted reader
    preload(14'h0200, 16'h5A5A);
    gs = grants.size(); n0 = wlog_addr.size();
    bus.disp_req = 1'b1; bus.disp_addr = 14'h0200;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr = 1'b1; bus.cpu_addr = 14'(32'h100 + i); bus.cpu_wdata = 16'(32'hC000 + i);
      tick();
    end
    bus.cpu_wr = 1'b0;
    budget = 0;
    while (grants.size() < gs + 9 && budget < 300) begin
      tick();
      budget++;
    end
    check("starve.in_time", budget < 300, 1);
    bus.disp_req = 1'b0;
    tick(20);
    exp_s = "RRWRRWRRW";
    for (int i = 0; i < 9; i++)
      check($sformatf("starve.grant%0d", i),
            (gs + i < grants.size()) ? grants[gs + i] : 8'h00, exp_s[i]);
    check("starve.n_writes", wlog_addr.size(), n0 + 3);
    for (int i = 0; i < 3; i++)
      if (n0 + i < wlog_addr.size()) begin
        check($sformatf("starve.waddr%0d", i), wlog_addr[n0 + i], 32'h100 + i);
        check($sformatf("starve.wdata%0d", i), wlog_data[n0 + i], 32'hC000 + i);
      end

    // Overflow and full override: five writes while a read is in flight
    preload(14'h0300, 16'h1111);
    preload(14'h0301, 16'h2222);
    gs = grants.size(); n0 = wlog_addr.size();
    bus.disp_req = 1'b1; bus.disp_addr = 14'h0300;
    tick();
    bus.disp_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.cpu_wr = 1'b1; bus.cpu_addr = 14'(32'h400 + i); bus.cpu_wdata = 16'(32'hD000 + i);
      if (i == 4) begin
        check("ovf.full_after4", bus.cpu_full, 1);
        check("ovf.not_yet", bus.cpu_overflow, 0);
        check("ovf.ready_for_2nd", bus.disp_ready, 1);
        bus.disp_req = 1'b1; bus.disp_addr = 14'h0301;
      end
      tick();
    end
    bus.cpu_wr = 1'b0; bus.disp_req = 1'b0;
    check("ovf.set", bus.cpu_overflow, 1);
    check("ovf.read_pending", bus.disp_ready, 0);
    tick(40);
    exp_s = "RWRWWW";
    check("ovf.n_grants", grants.size(), gs + 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("ovf.grant%0d", i),
            (gs + i < grants.size()) ? grants[gs + i] : 8'h00, exp_s[i]);
    if (gs + 1 < grant_cyc.size())
      check("ovf.override_gap", grant_cyc[gs + 1] - grant_cyc[gs], 6);
    check("ovf.n_writes", wlog_addr.size(), n0 + 4);
    for (int i = 0; i < 4; i++)
      if (n0 + i < wlog_addr.size()) begin
        check($sformatf("ovf.waddr%0d", i), wlog_addr[n0 + i], 32'h400 + i);
        check($sformatf("ovf.wdata%0d", i), wlog_data[n0 + i], 32'hD000 + i);
      end
    check("ovf.sticky", bus.cpu_overflow, 1);
    check("ovf.not_full", bus.cpu_full, 0);
    check("ovf.second_read_data", bus.disp_data, 16'h2222);

    // Reset in the cycle after wren, with a second entry still queued
    n0 = wlog_addr.size();
    bus.cpu_wr = 1'b1; bus.cpu_addr = 14'h0ABC; bus.cpu_wdata = 16'h7E57;
    tick();
    bus.cpu_addr = 14'h0ABD; bus.cpu_wdata = 16'h0001;
    tick();
    bus.cpu_wr = 1'b0;
    check("rst.wren_before", bus.vram_wren, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_outputs("rst");
    tick(10);
    check("rst.fifo_flushed", wlog_addr.size(), n0 + 1);
    do_read(14'h0ABC, 16'h7E57, "post_rst_rd");
    do_write(14'h0ABD, 16'h0002, "post_rst_wr");

    check("strobe_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates the shared single-port video RAM between two requesters: the display scan-out (random reads) and the CPU (posted writes).
- CPU writes are posted into a small FIFO and drained to the VRAM write port one at a time.
- Display reads take priority, but a starvation counter and FIFO-full override guarantee write progress.
- The block sits between the CPU/display logic and the shared VRAM wrapper. It issues at most one VRAM transaction at a time, and each is a single-cycle request pulse.

Parameters:
- DEPTH, 4: write FIFO entries. Must be a power of 2, at least 2.
- RD_LAT, 4: cycles from the vram_rden-high cycle to the disp_valid-high cycle.
- STARVE_MAX, 2: maximum consecutive read grants while the FIFO is non-empty before a write is forced.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- disp_req  in  1  display read request; accepted when disp_req && disp_ready
- disp_addr  in  14  display read word address
- disp_ready  out  1  high when no display read is pending or in flight
- disp_data  out  16  read data; valid while disp_valid is high, held afterwards
- disp_valid  out  1  one-cycle pulse carrying read data
- cpu_wr  in  1  CPU write strobe; accepted when cpu_wr && !cpu_full
- cpu_addr  in  14  CPU write word address
- cpu_wdata  in  16  CPU write data
- cpu_full  out  1  FIFO count == DEPTH
- cpu_overflow  out  1  sticky; set when cpu_wr && cpu_full
- vram_rden  out  1  VRAM read request pulse
- vram_raddr  out  14  VRAM read address
- vram_rdata  in  16  VRAM read data
- vram_wren  out  1  VRAM write request pulse
- vram_waddr  out  14  VRAM write address
- vram_wdata  out  16  VRAM write data
- vram_wrack  in  1  VRAM write acknowledge

Behaviour:
- Reset (reset==0, sampled on clk):
  - FSM to IDLE; FIFO emptied; read-pending flag cleared; starve counter 0.
  - All outputs 0, except disp_ready=1.
  - cpu_overflow cleared.
  - Reset mid-transaction abandons it. Late vram_wrack or vram_rdata after reset is ignored.
- Display acceptance:
  - disp_req && disp_ready registers disp_addr and sets the pending flag.
  - disp_ready is low from the next cycle until the cycle disp_valid is high; it returns high in that same cycle.
- CPU FIFO:
  - Push on cpu_wr && !cpu_full.
  - Pop when a write is issued.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - A push while full is dropped, sets cpu_overflow, and leaves the FIFO untouched.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: choose a transaction from registered state.
    - Write wins if the FIFO is non-empty and (FIFO full, or starve==STARVE_MAX, or no read pending).
    - Otherwise read wins if a read is pending.
    - Otherwise stay in IDLE.
  - Read grant:
    - vram_rden=1 and vram_raddr=pending address, for exactly one cycle R.
    - starve increments (saturating at STARVE_MAX) if the FIFO was non-empty, else it is cleared.
    - Go to RD_WAIT.
  - RD_WAIT:
    - Count cycles; capture vram_rdata at the end of cycle R+RD_LAT-1.
    - disp_valid=1 in cycle R+RD_LAT; clear the pending flag; go to IDLE.
  - Write grant:
    - vram_wren=1 and vram_waddr/vram_wdata = FIFO head, for exactly one cycle W; pop the FIFO.
    - starve cleared. Go to WR_WAIT.
  - WR_WAIT:
    - Stay until vram_wrack==1, then go to IDLE. vram_waddr/vram_wdata are held.
    - vram_wrack arrives at W+2. A vram_wrack outside WR_WAIT is ignored.
- Request signalling:
  - vram_rden and vram_wren are never high together. Neither is ever high for two consecutive cycles.
  - The VRAM wrapper re-samples wren after acking, so a held wren would cause a duplicate write.
- Issue turnaround: the next grant is issued no earlier than the cycle after the FSM re-enters IDLE.
- Minimum display latency: disp_req accepted in cycle A gives vram_rden in cycle A+2 (idle FSM, empty FIFO) and disp_valid in cycle A+2+RD_LAT.
- Hazard: no read-after-write forwarding. A display read may return the pre-write value while a write to the same address is queued.

Test Plan:
- Single read:
  - Stimulus: idle, FIFO empty, disp_req with addr 0x0123; VRAM model returns 0xBEEF.
  - Response: vram_rden for one cycle at A+2 with raddr 0x0123; disp_valid at A+6 with disp_data 0xBEEF; disp_ready low for A+1..A+5.
- Single write:
  - Stimulus: cpu_wr addr 0x0040, data 0x1234.
  - Response: one vram_wren pulse with waddr 0x0040, wdata 0x1234; FSM back to IDLE after wrack; exactly one write seen by the model.
- Starvation:
  - Stimulus: 3 writes queued; disp_req re-asserted every time disp_ready is high.
  - Response: grant order R,R,W,R,R,W,R,R,W (STARVE_MAX=2); no FIFO entry lost or reordered.
- Overflow:
  - Stimulus: 5 back-to-back cpu_wr while a read is in flight.
  - Response: cpu_full high after the 4th; 5th dropped; cpu_overflow=1 and stays set; first 4 writes drain in order.
- Full override:
  - Stimulus: FIFO full with a read pending.
  - Response: next grant is a write even with starve=0.
- Reset mid-write:
  - Stimulus: assert reset (0) in the cycle after vram_wren.
  - Response: all outputs 0, disp_ready=1, FIFO empty; late vram_wrack ignored; the next transaction proceeds normally.
